// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan
// Description : Time-multiplexed 7-segment display driver. Latches packed BCD
//               digits on a valid strobe into a pending register and swaps
//               them into the displayed snapshot only at frame boundaries.
//               Scans one digit per slot with an all-anodes-off guard window,
//               leading-zero blanking, decimal points and a dash error glyph.
//               All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan #(
  parameter int IN_W     = 25,
  parameter int DIGITS   = 6,
  parameter int TICK_DIV = 50000,
  parameter int GUARD    = 500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IN_W-1:0]   bcd,
  input  logic              bcd_valid,
  input  logic [DIGITS-1:0] dp_mask,
  input  logic              blank_en,
  output logic [DIGITS-1:0] an_n,
  output logic [6:0]        seg_n,
  output logic              dp_n,
  output logic              frame_start
);

  localparam int C_BW = 4 * DIGITS;
  localparam int C_PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int C_DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [C_PW-1:0] C_P_LAST = C_PW'(TICK_DIV - 1);
  localparam logic [C_PW-1:0] C_GUARD  = C_PW'(GUARD);
  localparam logic [C_DW-1:0] C_D_LAST = C_DW'(DIGITS - 1);

  // Glyphs, active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] C_SEG_0    = 7'b1000000;
  localparam logic [6:0] C_SEG_1    = 7'b1111001;
  localparam logic [6:0] C_SEG_2    = 7'b0100100;
  localparam logic [6:0] C_SEG_3    = 7'b0110000;
  localparam logic [6:0] C_SEG_4    = 7'b0011001;
  localparam logic [6:0] C_SEG_5    = 7'b0010010;
  localparam logic [6:0] C_SEG_6    = 7'b0000010;
  localparam logic [6:0] C_SEG_7    = 7'b1111000;
  localparam logic [6:0] C_SEG_8    = 7'b0000000;
  localparam logic [6:0] C_SEG_9    = 7'b0010000;
  localparam logic [6:0] C_SEG_DASH = 7'b0111111;
  localparam logic [6:0] C_SEG_OFF  = 7'h7F;

  // --------------------------------------------------------------------------
  // Input width adaptation: only the low 4*DIGITS bits carry digits.
  // --------------------------------------------------------------------------
  logic [C_BW-1:0] w_bcd_in;

  if (IN_W > C_BW) begin : g_in_trim
    logic unused_bcd_hi;
    assign w_bcd_in      = bcd[C_BW-1:0];
    assign unused_bcd_hi = ^bcd[IN_W-1:C_BW];
  end else if (IN_W == C_BW) begin : g_in_exact
    assign w_bcd_in = bcd;
  end else begin : g_in_pad
    assign w_bcd_in = {{(C_BW - IN_W){1'b0}}, bcd};
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [C_PW-1:0]   p_q, p_d;
  logic [C_DW-1:0]   d_q, d_d;
  logic [C_BW-1:0]   pend_bcd_q, pend_bcd_d;
  logic [DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic [C_BW-1:0]   snap_bcd_q, snap_bcd_d;
  logic [DIGITS-1:0] snap_dp_q, snap_dp_d;
  logic [DIGITS-1:0] an_n_q, an_n_d;
  logic [6:0]        seg_n_q, seg_n_d;
  logic              dp_n_q, dp_n_d;
  logic              frame_start_q, frame_start_d;

  logic              w_tick;
  logic              w_boundary;
  logic [DIGITS-1:0] w_blank;
  logic [3:0]        w_nib;
  logic              w_dp_sel;
  logic              w_blank_sel;
  logic [6:0]        w_glyph;

  // Slot prescaler and digit index; a frame ends on the last slot's tick
  always_comb begin
    w_tick     = (p_q == C_P_LAST);
    w_boundary = w_tick && (d_q == C_D_LAST);
    p_d        = w_tick ? '0 : p_q + C_PW'(1);
    d_d        = d_q;
    if (w_tick) begin
      d_d = (d_q == C_D_LAST) ? '0 : d_q + C_DW'(1);
    end
  end

  // Pending captures every strobe; snapshot swaps only at the frame boundary,
  // taking a coincident strobe directly so the newest value is never skipped
  always_comb begin
    pend_bcd_d = pend_bcd_q;
    pend_dp_d  = pend_dp_q;
    snap_bcd_d = snap_bcd_q;
    snap_dp_d  = snap_dp_q;
    if (bcd_valid) begin
      pend_bcd_d = w_bcd_in;
      pend_dp_d  = dp_mask;
    end
    if (w_boundary) begin
      if (bcd_valid) begin
        snap_bcd_d = w_bcd_in;
        snap_dp_d  = dp_mask;
      end else begin
        snap_bcd_d = pend_bcd_q;
        snap_dp_d  = pend_dp_q;
      end
    end
  end

  // Leading-zero blanking: digit k dark when it and everything above is zero
  always_comb begin
    w_blank = '0;
    for (int k = 1; k < DIGITS; k++) begin
      w_blank[k] = blank_en && ((snap_bcd_q >> (4 * k)) == '0);
    end
  end

  // Select the nibble, dp bit and blank flag of the digit being scanned
  always_comb begin
    w_nib       = '0;
    w_dp_sel    = 1'b0;
    w_blank_sel = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (d_q == C_DW'(k)) begin
        w_nib       = snap_bcd_q[4*k +: 4];
        w_dp_sel    = snap_dp_q[k];
        w_blank_sel = w_blank[k];
      end
    end
  end

  // BCD to active-low glyph; non-decimal nibbles show a dash
  always_comb begin
    w_glyph = C_SEG_DASH;
    case (w_nib)
      4'd0:    w_glyph = C_SEG_0;
      4'd1:    w_glyph = C_SEG_1;
      4'd2:    w_glyph = C_SEG_2;
      4'd3:    w_glyph = C_SEG_3;
      4'd4:    w_glyph = C_SEG_4;
      4'd5:    w_glyph = C_SEG_5;
      4'd6:    w_glyph = C_SEG_6;
      4'd7:    w_glyph = C_SEG_7;
      4'd8:    w_glyph = C_SEG_8;
      4'd9:    w_glyph = C_SEG_9;
      default: w_glyph = C_SEG_DASH;
    endcase
  end

  // Next output values: one anode low only after the guard window
  always_comb begin
    an_n_d = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if ((d_q == C_DW'(k)) && (p_q >= C_GUARD) && !w_blank_sel) begin
        an_n_d[k] = 1'b0;
      end
    end
    seg_n_d       = w_glyph;
    dp_n_d        = ~(w_dp_sel & ~w_blank_sel);
    frame_start_d = w_boundary;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q           <= '0;
      d_q           <= '0;
      pend_bcd_q    <= '0;
      pend_dp_q     <= '0;
      snap_bcd_q    <= '0;
      snap_dp_q     <= '0;
      an_n_q        <= '1;
      seg_n_q       <= C_SEG_OFF;
      dp_n_q        <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      p_q           <= p_d;
      d_q           <= d_d;
      pend_bcd_q    <= pend_bcd_d;
      pend_dp_q     <= pend_dp_d;
      snap_bcd_q    <= snap_bcd_d;
      snap_dp_q     <= snap_dp_d;
      an_n_q        <= an_n_d;
      seg_n_q       <= seg_n_d;
      dp_n_q        <= dp_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an_n        = an_n_q;
  assign seg_n       = seg_n_q;
  assign dp_n        = dp_n_q;
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan
// Description : Self-checking bench for seg7_scan. A cycle-count reference
//               model derives slot/digit position arithmetically and predicts
//               every registered output; directed steps plus random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan;

  localparam int IN_W     = 25;
  localparam int DIGITS   = 6;
  localparam int TICK_DIV = 4;
  localparam int GUARD    = 1;
  localparam int FRAME    = TICK_DIV * DIGITS;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [IN_W-1:0]   bcd = '0;
  logic              bcd_valid = 1'b0;
  logic [DIGITS-1:0] dp_mask = '0;
  logic              blank_en = 1'b0;
  logic [DIGITS-1:0] an_n;
  logic [6:0]        seg_n;
  logic              dp_n;
  logic              frame_start;

  int n_tests = 0;
  int n_fail  = 0;

  seg7_scan #(
    .IN_W(IN_W), .DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .GUARD(GUARD)
  ) u_dut (
    .clk(clk), .rst(rst), .bcd(bcd), .bcd_valid(bcd_valid),
    .dp_mask(dp_mask), .blank_en(blank_en), .an_n(an_n),
    .seg_n(seg_n), .dp_n(dp_n), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Reference model: m_n counts cycles since reset; position is pure arithmetic
  int                m_n;
  logic [4*DIGITS-1:0] m_pend_bcd, m_snap_bcd;
  logic [DIGITS-1:0] m_pend_dp, m_snap_dp;
  logic [DIGITS-1:0] e_an;
  logic [6:0]        e_seg;
  logic              e_dp, e_fs;
  int                e_d = -1, e_p = -1;
  bit                chk_en = 1'b0;
  int                m_slot, m_d, m_p, m_hi;
  bit                m_blank;

  always @(posedge clk) begin
    if (rst) begin
      m_n = 0;
      m_pend_bcd = '0; m_snap_bcd = '0; m_pend_dp = '0; m_snap_dp = '0;
      e_an = '1; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
      e_d = -1; e_p = -1;
      chk_en = 1'b1;
    end else begin
      m_slot = m_n / TICK_DIV;
      m_d    = m_slot % DIGITS;
      m_p    = m_n % TICK_DIV;
      m_hi   = 0;
      for (int k = 0; k < DIGITS; k++)
        if (m_snap_bcd[4*k +: 4] != 4'd0) m_hi = k;
      m_blank = blank_en && (m_d > m_hi);
      e_d   = m_d;
      e_p   = m_p;
      e_seg = glyph(m_snap_bcd[4*m_d +: 4]);
      e_dp  = !(m_snap_dp[m_d] && !m_blank);
      e_an  = '1;
      if (m_p >= GUARD && !m_blank) e_an[m_d] = 1'b0;
      e_fs  = ((m_n % FRAME) == FRAME - 1);
      if (e_fs) begin
        m_snap_bcd = bcd_valid ? bcd[4*DIGITS-1:0] : m_pend_bcd;
        m_snap_dp  = bcd_valid ? dp_mask : m_pend_dp;
      end
      if (bcd_valid) begin
        m_pend_bcd = bcd[4*DIGITS-1:0];
        m_pend_dp  = dp_mask;
      end
      m_n++;
    end
  end

  // Continuous comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check_val("an_n", 32'(an_n), 32'(e_an));
      check_val("seg_n", 32'(seg_n), 32'(e_seg));
      check_val("dp_n", 32'(dp_n), 32'(e_dp));
      check_val("frame_start", 32'(frame_start), 32'(e_fs));
      check_val("an_at_most_one", 32'($countones(~an_n) <= 1), 32'd1);
    end
  end

  task automatic wait_slot(input int dd, input int pp);
    for (int i = 0; i < 10 * FRAME; i++) begin
      @(negedge clk);
      if (e_d == dd && e_p == pp) return;
    end
    check_val("wait_slot_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_pos(input int r);
    for (int i = 0; i < 10 * FRAME; i++) begin
      @(negedge clk);
      if ((m_n % FRAME) == r) return;
    end
    check_val("wait_pos_timeout", 32'd0, 32'd1);
  endtask

  task automatic strobe(input logic [IN_W-1:0] v, input logic [DIGITS-1:0] dm);
    bcd = v; dp_mask = dm; bcd_valid = 1'b1;
    @(negedge clk);
    bcd_valid = 1'b0;
  endtask

  initial begin
    int nd;
    logic [IN_W-1:0] rv;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Scan order and guard gap
    wait_slot(0, 1); check_val("an_slot0", 32'(an_n), 32'h3E);
    wait_slot(5, 3); check_val("an_slot5", 32'(an_n), 32'h1F);
    wait_slot(0, 0); check_val("an_guard", 32'(an_n), 32'h3F);

    // Mid-frame strobe appears only from next frame; bit 24 is ignored
    wait_pos(10);
    strobe(25'h1524287, '0);
    wait_pos(0);
    wait_slot(0, 1); check_val("dig0_seven", 32'(seg_n), 32'h78);
    wait_slot(5, 1); check_val("dig5_five", 32'(seg_n), 32'h12);

    // Leading-zero blanking
    blank_en = 1'b1;
    wait_pos(6);
    strobe(25'h000042, '0);
    wait_pos(0);
    wait_slot(1, 2); check_val("blank_dig1_on", 32'(an_n), 32'h3D);
    check_val("blank_dig1_seg", 32'(seg_n), 32'h19);
    wait_slot(2, 2); check_val("blank_dig2_off", 32'(an_n), 32'h3F);
    wait_pos(6);
    strobe(25'h0, '0);
    wait_pos(0);
    wait_slot(0, 2); check_val("zero_dig0_seg", 32'(seg_n), 32'h40);
    check_val("zero_dig0_an", 32'(an_n), 32'h3E);

    // Error glyph and decimal point
    wait_pos(6);
    strobe(25'h00C000, 6'b000100);
    wait_pos(0);
    wait_slot(2, 2); check_val("dp_slot2", 32'(dp_n), 32'd0);
    wait_slot(3, 2); check_val("dash_slot3", 32'(seg_n), 32'h3F);
    check_val("dp_slot3", 32'(dp_n), 32'd1);
    blank_en = 1'b0;

    // Strobe on the boundary tick wins over older pending value
    wait_pos(5);
    strobe(25'h111111, '0);
    wait_pos(FRAME - 1);
    strobe(25'h999999, '0);
    wait_slot(0, 1); check_val("bypass_nine", 32'(seg_n), 32'h10);
    // Two strobes in one frame: last wins
    wait_pos(3);
    strobe(25'h333333, '0);
    wait_pos(8);
    strobe(25'h777777, '0);
    wait_pos(0);
    wait_slot(4, 2); check_val("last_wins", 32'(seg_n), 32'h78);

    // Reset during slot 4
    wait_pos(17);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("rst_an", 32'(an_n), 32'h3F);
    check_val("rst_seg", 32'(seg_n), 32'h7F);
    wait_slot(0, 1); check_val("rst_zero_seg", 32'(seg_n), 32'h40);
    check_val("rst_zero_an", 32'(an_n), 32'h3E);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      bcd_valid = 1'b0;
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0) blank_en = ~blank_en;
      if ($urandom_range(0, 7) == 0) begin
        nd = $urandom_range(0, DIGITS);
        rv = IN_W'($urandom);
        for (int k = 0; k < DIGITS; k++) begin
          if (k >= nd) rv[4*k +: 4] = 4'd0;
          else if ($urandom_range(0, 3) != 0) rv[4*k +: 4] = 4'($urandom_range(0, 9));
        end
        bcd = rv;
        dp_mask = DIGITS'($urandom);
        bcd_valid = 1'b1;
      end
      @(negedge clk);
    end
    rst = 1'b0;
    bcd_valid = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
